// File: rtl/conv_window_reader_pkg.sv
// Shared definitions for the conv window reader: default geometry, FSM states, helpers.
package conv_window_reader_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int ADDR_WIDTH_DEF = 13;
  localparam int IMG_W_DEF      = 32;
  localparam int IMG_H_DEF      = 32;
  localparam int K_DEF          = 5;
  localparam int WIN_BITS       = K_DEF * K_DEF * WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    PRESENT,
    DONE
  } state_e;

  // Bits needed to hold indices 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_reader_addr_gen.sv
// Window/pixel counters and read-address generation for conv_window_reader.
// WINDOW_REUSE_EN: windows with c > 0 fetch only their new right-hand column.
module win_addr_gen
  import conv_window_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int K          = K_DEF,
  parameter int CNT_W      = cnt_bits((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  fetch_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_en_o,
  output logic [CNT_W-1:0]      pix_i_o,
  output logic [CNT_W-1:0]      pix_j_o,
  output logic                  last_read_o,
  output logic                  last_window_o,
  output logic                  shift_o
);

`ifdef WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(IMG_W);
  localparam logic [CNT_W-1:0]      K_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0]      R_LAST = CNT_W'(IMG_H - K);
  localparam logic [CNT_W-1:0]      C_LAST = CNT_W'(IMG_W - K);

  logic [CNT_W-1:0]      r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
  logic [ADDR_WIDTH-1:0] row_org_q, row_org_d;  // address of pixel (r, 0)
  logic [ADDR_WIDTH-1:0] win_org_q, win_org_d;  // address of pixel (r, c)
  logic [ADDR_WIDTH-1:0] row_ptr_q, row_ptr_d;  // address of pixel (r+i, c)
  logic                  col_wrap;
  logic [CNT_W-1:0]      j_first;

  assign col_wrap = (c_q == C_LAST);
  assign j_first  = (REUSE && (c_q != '0)) ? K_LAST : '0;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    r_d       = r_q;
    c_d       = c_q;
    i_d       = i_q;
    j_d       = j_q;
    row_org_d = row_org_q;
    win_org_d = win_org_q;
    row_ptr_d = row_ptr_q;
    if (load_i) begin
      r_d       = '0;
      c_d       = '0;
      i_d       = '0;
      j_d       = '0;
      row_org_d = base_i;
      win_org_d = base_i;
      row_ptr_d = base_i;
    end else if (fetch_i) begin
      if (j_q == K_LAST) begin
        j_d       = j_first;
        i_d       = (i_q == K_LAST) ? '0 : i_q + 1'b1;
        row_ptr_d = row_ptr_q + STRIDE;
      end else begin
        j_d = j_q + 1'b1;
      end
    end else if (advance_i) begin
      i_d = '0;
      if (col_wrap) begin
        c_d       = '0;
        r_d       = r_q + 1'b1;
        row_org_d = row_org_q + STRIDE;
        win_org_d = row_org_q + STRIDE;
        row_ptr_d = row_org_q + STRIDE;
        j_d       = '0;
      end else begin
        c_d       = c_q + 1'b1;
        win_org_d = win_org_q + 1'b1;
        row_ptr_d = win_org_q + 1'b1;
        j_d       = REUSE ? K_LAST : '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      c_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      row_org_q <= '0;
      win_org_q <= '0;
      row_ptr_q <= '0;
    end else begin
      r_q       <= r_d;
      c_q       <= c_d;
      i_q       <= i_d;
      j_q       <= j_d;
      row_org_q <= row_org_d;
      win_org_q <= win_org_d;
      row_ptr_q <= row_ptr_d;
    end
  end

  assign rd_addr_o     = row_ptr_q + ADDR_WIDTH'(j_q);
  assign rd_en_o       = fetch_i;
  assign pix_i_o       = i_q;
  assign pix_j_o       = j_q;
  assign last_read_o   = (i_q == K_LAST) && (j_q == K_LAST);
  assign last_window_o = (r_q == R_LAST) && col_wrap;
  assign shift_o       = REUSE && advance_i && !col_wrap;

endmodule

// File: rtl/conv_window_reader.sv
// Walks every KxK window of a row-major feature map and assembles each into one wide word.
// WINDOW_REUSE_EN: reuse K-1 columns between horizontally adjacent windows.
module conv_window_reader
  import conv_window_reader_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int K          = K_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [WIDTH-1:0]      rd_data,
  output logic [K*K*WIDTH-1:0]  win_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = cnt_bits((IMG_W > IMG_H) ? IMG_W : IMG_H);

  state_e               state_q, state_d;
  logic                 load, fetch, advance;
  logic                 last_read, last_window, shift;
  logic [CNT_W-1:0]     pix_i, pix_j;
  logic                 cap_vld_q;
  logic [CNT_W-1:0]     cap_i_q, cap_j_q;
  logic [K*K*WIDTH-1:0] win_q;

  win_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .K         (K),
    .CNT_W     (CNT_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .base_i       (base_addr),
    .fetch_i      (fetch),
    .advance_i    (advance),
    .rd_addr_o    (rd_addr),
    .rd_en_o      (rd_en),
    .pix_i_o      (pix_i),
    .pix_j_o      (pix_j),
    .last_read_o  (last_read),
    .last_window_o(last_window),
    .shift_o      (shift)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fetch   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        fetch = 1'b1;
        if (last_read) state_d = DRAIN;
      end
      DRAIN:   state_d = PRESENT;
      PRESENT: begin
        if (win_ready) begin
          if (last_window) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pixels land one cycle after their read; the (i,j) tag travels with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q <= 1'b0;
      cap_i_q   <= '0;
      cap_j_q   <= '0;
      // NOTE: the window register is reset on purpose; a fresh pass must never expose stale pixels.
      win_q     <= '0;
    end else begin
      cap_vld_q <= fetch;
      cap_i_q   <= pix_i;
      cap_j_q   <= pix_j;
`ifdef WINDOW_REUSE_EN
      if (shift) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) begin
            win_q[(i*K+j)*WIDTH +: WIDTH] <= win_q[(i*K+j+1)*WIDTH +: WIDTH];
          end
        end
      end
`endif
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          if (cap_vld_q && (cap_i_q == CNT_W'(i)) && (cap_j_q == CNT_W'(j))) begin
            win_q[(i*K+j)*WIDTH +: WIDTH] <= rd_data;
          end
        end
      end
    end
  end

`ifndef WINDOW_REUSE_EN
  logic unused_shift;
  assign unused_shift = shift;
`endif

  assign win_data  = win_q;
  assign win_valid = (state_q == PRESENT);
  assign busy      = (state_q == FETCH) || (state_q == DRAIN) || (state_q == PRESENT);
  assign done      = (state_q == DONE);

endmodule
